// File: rtl/shift_q_tx.sv
// Parallel-in, serial-out frame transmitter: loads an L-bit word on V & RDY and
// shifts it out MSB first on Q, with E marking each valid bit and DONE the last.
module shift_q_tx #(
  parameter int unsigned L   = 80,
  parameter int unsigned GAP = 0,
  parameter int unsigned CW  = $clog2(L)
) (
  input  logic          C,
  input  logic          RN,
  input  logic [L-1:0]  D,
  input  logic          V,
  output logic          RDY,
  output logic          Q,
  output logic          E,
  output logic          DONE,
  output logic [CW-1:0] CNT
);

  localparam int unsigned   GW      = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] LastIdx = CW'(L - 1);
  localparam logic [GW-1:0] GapLast = (GAP > 0) ? GW'(GAP - 1) : '0;

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e        state_q, state_d;
  logic [L-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          e_q, e_d;
  logic          done_q, done_d;
  logic          last_bit;
  logic          load;

  assign last_bit = (state_q == StShift) && (cnt_q == LastIdx);
  // Back-to-back reload on the last bit is only possible when no idle gap is required.
  assign RDY      = (state_q == StIdle) || (last_bit && (GAP == 0));
  assign load     = V && RDY;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    e_d     = e_q;
    if (load) begin
      state_d = StShift;
      sr_d    = D;
      cnt_d   = '0;
      e_d     = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: ;
        StShift: begin
          if (last_bit) begin
            // Clearing the shifter keeps Q low whenever E is low.
            sr_d    = '0;
            cnt_d   = '0;
            gcnt_d  = '0;
            e_d     = 1'b0;
            state_d = (GAP == 0) ? StIdle : StGap;
          end else begin
            sr_d  = {sr_q[L-2:0], 1'b0};
            cnt_d = cnt_q + CW'(1);
          end
        end
        StGap: begin
          if (gcnt_q == GapLast) begin
            state_d = StIdle;
          end else begin
            gcnt_d = gcnt_q + GW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
    done_d = (state_d == StShift) && (cnt_d == LastIdx);
  end

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      e_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      e_q     <= e_d;
      done_q  <= done_d;
    end
  end

  assign Q    = sr_q[L-1];
  assign E    = e_q;
  assign DONE = done_q;
  assign CNT  = cnt_q;

endmodule

// File: tb/tb_shift_q_tx.sv
// Bench for shift_q_tx: directed frames on L=8 (GAP 0 and 3) plus an L=80 loopback
// into a falling-edge serial-in receiver, with per-bit scoreboards.
module tb_shift_q_tx;

  typedef struct {
    logic q;
    logic last;
  } exp_t;

  logic        clk, rn;
  logic        va, ra, qa, ea, donea;
  logic [7:0]  da;
  logic [2:0]  cnta;
  logic        vb, rb, qb, eb, doneb;
  logic [7:0]  db;
  logic [2:0]  cntb;
  logic        vc, rc, qc, ec, donec;
  logic [79:0] dc;
  logic [6:0]  cntc;
  logic [79:0] rx;
  logic [79:0] word;
  logic [95:0] rnd;
  logic        got;

  exp_t qa_exp[$];
  exp_t qb_exp[$];
  int   n_pass  = 0;
  int   n_total = 0;

  shift_q_tx #(.L(8), .GAP(0)) dut_a (
    .C(clk), .RN(rn), .D(da), .V(va), .RDY(ra), .Q(qa), .E(ea), .DONE(donea), .CNT(cnta)
  );
  shift_q_tx #(.L(8), .GAP(3)) dut_b (
    .C(clk), .RN(rn), .D(db), .V(vb), .RDY(rb), .Q(qb), .E(eb), .DONE(doneb), .CNT(cntb)
  );
  shift_q_tx #(.L(80), .GAP(0)) dut_c (
    .C(clk), .RN(rn), .D(dc), .V(vc), .RDY(rc), .Q(qc), .E(ec), .DONE(donec), .CNT(cntc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_a(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) qa_exp.push_back('{q: w[i], last: (i == 0)});
  endtask

  task automatic push_b(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) qb_exp.push_back('{q: w[i], last: (i == 0)});
  endtask

  // Receiver: serial-in shift register sampling mid-bit.
  initial rx = '0;
  always @(negedge clk) if (ec) rx <= {rx[78:0], qc};

  always @(negedge clk) begin
    exp_t s;
    if (ea) begin
      if (qa_exp.size() == 0) chk("a_extra_bit", ea, 1'b0);
      else begin
        s = qa_exp.pop_front();
        chk("a_q", qa, s.q);
        chk("a_done", donea, s.last);
      end
    end else begin
      chk("a_idle_q", qa, 1'b0);
      chk("a_idle_done", donea, 1'b0);
    end
  end

  always @(negedge clk) begin
    exp_t s;
    if (eb) begin
      if (qb_exp.size() == 0) chk("b_extra_bit", eb, 1'b0);
      else begin
        s = qb_exp.pop_front();
        chk("b_q", qb, s.q);
        chk("b_done", doneb, s.last);
      end
    end else begin
      chk("b_idle_q", qb, 1'b0);
      chk("b_idle_done", doneb, 1'b0);
    end
  end

  initial begin
    int k;
    rn = 1'b0;
    va = 1'b0; vb = 1'b0; vc = 1'b0;
    da = '0;   db = '0;   dc = '0;
    nclk(2);
    chk("rst_rdy_a", ra, 1'b1);
    chk("rst_e_a", ea, 1'b0);
    chk("rst_q_a", qa, 1'b0);
    chk("rst_done_a", donea, 1'b0);
    chk("rst_cnt_a", cnta, 3'd0);
    chk("rst_rdy_b", rb, 1'b1);
    chk("rst_rdy_c", rc, 1'b1);
    rn = 1'b1;
    nclk(1);

    // Single A5 frame.
    da = 8'hA5; va = 1'b1; push_a(8'hA5);
    nclk(1); va = 1'b0;
    chk("a5_first_e", ea, 1'b1);
    chk("a5_first_cnt", cnta, 3'd0);
    nclk(7);
    chk("a5_last_cnt", cnta, 3'd7);
    chk("a5_last_done", donea, 1'b1);
    chk("a5_last_rdy", ra, 1'b1);
    nclk(1);
    chk("a5_after_e", ea, 1'b0);
    chk("a5_after_rdy", ra, 1'b1);
    chk("a5_after_cnt", cnta, 3'd0);
    chk("a5_drain", qa_exp.size(), 0);

    // V held high: FF then 00 back to back.
    da = 8'hFF; va = 1'b1; push_a(8'hFF);
    for (int i = 1; i <= 16; i++) begin
      nclk(1);
      if (i == 8) begin da = 8'h00; push_a(8'h00); end
      if (i == 16) va = 1'b0;
      chk("b2b_e", ea, 1'b1);
      chk("b2b_done", donea, (i == 8 || i == 16));
    end
    nclk(1);
    chk("b2b_after_e", ea, 1'b0);
    chk("b2b_after_rdy", ra, 1'b1);
    chk("b2b_drain", qa_exp.size(), 0);

    // V pulsed mid-frame is ignored.
    da = 8'hA5; va = 1'b1; push_a(8'hA5);
    nclk(1); va = 1'b0;
    nclk(3);
    chk("ign_cnt3", cnta, 3'd3);
    chk("ign_rdy", ra, 1'b0);
    va = 1'b1; da = 8'h3C;
    nclk(1); va = 1'b0; da = 8'h00;
    nclk(4);
    chk("ign_no_second", ea, 1'b0);
    nclk(3);
    chk("ign_still_idle", ea, 1'b0);
    chk("ign_drain", qa_exp.size(), 0);

    // GAP=3 between two back-to-back requests.
    db = 8'hC3; vb = 1'b1; push_b(8'hC3);
    nclk(1); db = 8'h5A;
    chk("gap_first_e", eb, 1'b1);
    nclk(7);
    chk("gap_last_done", doneb, 1'b1);
    chk("gap_last_rdy", rb, 1'b0);
    for (int i = 0; i < 3; i++) begin
      nclk(1);
      chk("gap_e", eb, 1'b0);
      chk("gap_q", qb, 1'b0);
      chk("gap_rdy", rb, 1'b0);
    end
    nclk(1);
    chk("gap_rdy_back", rb, 1'b1);
    chk("gap_idle_e", eb, 1'b0);
    push_b(8'h5A);
    nclk(1); vb = 1'b0;
    chk("gap_second_e", eb, 1'b1);
    chk("gap_second_cnt", cntb, 3'd0);
    nclk(8);
    chk("gap_tail_e", eb, 1'b0);
    chk("gap_tail_rdy", rb, 1'b0);
    chk("gap_drain", qb_exp.size(), 0);

    // L=80 loopback into the receiver model.
    for (int w = 0; w < 100; w++) begin
      rnd  = {$urandom, $urandom, $urandom};
      word = rnd[79:0];
      dc   = word;
      vc   = 1'b1;
      nclk(1); vc = 1'b0;
      got = 1'b0;
      k   = 0;
      while (!got && k < 100) begin
        if (donec) got = 1'b1;
        else begin nclk(1); k++; end
      end
      chk("loop_done_seen", got, 1'b1);
      nclk(1); #1;
      chk("loop_word", rx, word);
    end

    // Reset mid-frame at CNT=4, then a fresh 81 frame.
    nclk(1);
    da = 8'hA5; va = 1'b1; push_a(8'hA5);
    nclk(1); va = 1'b0;
    nclk(4);
    chk("rst_mid_cnt4", cnta, 3'd4);
    #2 rn = 1'b0;
    #1;
    chk("rst_mid_e", ea, 1'b0);
    chk("rst_mid_q", qa, 1'b0);
    chk("rst_mid_done", donea, 1'b0);
    chk("rst_mid_cnt", cnta, 3'd0);
    qa_exp.delete();
    nclk(2);
    rn = 1'b1;
    chk("rst_rel_rdy", ra, 1'b1);
    chk("rst_rel_e", ea, 1'b0);
    da = 8'h81; va = 1'b1; push_a(8'h81);
    nclk(1); va = 1'b0;
    chk("x81_first_q", qa, 1'b1);
    chk("x81_first_cnt", cnta, 3'd0);
    nclk(8);
    chk("x81_after_e", ea, 1'b0);
    chk("x81_drain", qa_exp.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shift_q_tx.md
Name: shift_q_tx

Overview:
- Parallel-in, serial-out frame transmitter for the bit-serial link whose receive end is a serial-in shift register.
- Accepts an L-bit word through a valid/ready handshake and emits it MSB first, one bit per clock on Q.
- Asserts a bit-valid strobe E for every transmitted bit; the E/Q pair drives the receiver's enable and data inputs directly.
- Frame ordering is MSB first: after L receiver shifts the receiver's captured word equals the loaded word, bit for bit.

Parameters:
- L, 80, frame length in bits (L >= 2).
- GAP, 0, number of idle cycles inserted after each frame (E=0, Q=0); 0 permits back-to-back frames.
- CW, $clog2(L), width of the bit counter (derived; do not override).

Ports:
- C  input  1  clock. All state updates on the rising edge. The receiver samples on the falling edge, i.e. mid-bit.
- RN  input  1  reset, asynchronous, active-low.
- D  input  L  parallel frame word, sampled when V & RDY at a rising edge.
- V  input  1  load request (valid).
- RDY  output  1  transmitter can accept a word this cycle.
- Q  output  1  serial data, registered.
- E  output  1  bit-valid strobe, registered. High exactly while Q carries a frame bit.
- DONE  output  1  registered one-cycle pulse, coincident with the last bit (bit 0) of each frame.
- CNT  output  CW  index of the bit currently on Q, counting 0..L-1 from the MSB. Reads 0 outside SHIFT.

Behaviour:
- Reset (RN=0, asynchronous):
  - state=IDLE; shift register, CNT and gap counter cleared.
  - Q=0, E=0, DONE=0.
  - RDY reads 1 (combinational from state), but no load occurs while RN=0.
- States: IDLE, SHIFT, GAP.
- RDY = (state==IDLE) | (state==SHIFT & CNT==L-1 & GAP==0). RDY is combinational from registered state only and never depends on V.
- Load (V & RDY at a rising edge):
  - Shift register <= D.
  - Next cycle: Q=D[L-1], E=1, CNT=0, state=SHIFT.
  - Latency from accepting edge to first bit on Q: 1 clock.
- SHIFT, each rising edge: shift left by one. Q presents successive bits D[L-1], D[L-2] ... D[0]. CNT increments by 1. E stays 1.
- Last bit (CNT==L-1): DONE=1 in the same cycle. On the following edge:
  - GAP==0 and V=1: reload as per Load. E stays 1 with no bubble, CNT returns to 0.
  - GAP==0 and V=0: go to IDLE; E=0, Q=0.
  - GAP>0: go to GAP; E=0, Q=0, gap counter=0.
- GAP: count GAP cycles; after the GAP-th cycle go to IDLE. RDY=0 and V is ignored throughout GAP.
- V asserted in SHIFT while RDY=0: ignored. D is not sampled and the frame in flight is unaffected.
- D changes after acceptance: no effect; the word is held internally.
- Reset mid-frame: frame abandoned immediately. E and Q drop to 0 asynchronously, DONE does not pulse, and the transmitter is in IDLE at reset release.
- CNT never exceeds L-1. No wrap to an out-of-range value for non-power-of-2 L.
- Q=0 whenever E=0.

Test Plan:
- L=8, GAP=0: load D=8'hA5 with one V pulse -> Q = 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 clock after acceptance. E high for exactly 8 cycles, DONE high only on the 8th, then IDLE with RDY=1.
- Loopback L=80: drive the receiver with E/Q on the shared clock and load a random 80-bit word -> the receiver's captured word equals D one clock after DONE. Repeat for 100 random words.
- L=8, GAP=0, V held high with D=8'hFF then 8'h00 -> E continuously high for 16 cycles, Q = eight 1s then eight 0s, DONE pulses on cycles 8 and 16.
- L=8, GAP=3: two words presented back-to-back -> 3 cycles with E=0, Q=0, RDY=0 between frames, and the second frame starts 1 clock after RDY re-asserts.
- L=8: V pulsed with D=8'h3C during CNT=3 of a frame carrying 8'hA5 -> ignored. Frame still outputs 8'hA5 and no second frame follows.
- Reset pulse (RN=0 for 2 cycles) at CNT=4 -> E=0, Q=0, DONE=0 immediately. After release, RDY=1, and a new load of 8'h81 transmits correctly from bit 7.
